// File: rtl/updi_pkg.sv
// Shared UPDI definitions for the TX frame, double-break and RX stages.
// UPDI_TX_GUARD_EN adds the GUARD state to the TX state enum.
package updi_pkg;

   localparam int       UPDI_FRAME_BITS = 12;
   localparam logic [7:0] UPDI_SYNCH    = 8'h55;
   localparam logic     UPDI_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP1,
      TX_STOP2
`ifdef UPDI_TX_GUARD_EN
      ,TX_GUARD
`endif
   } updi_tx_state_t;

endpackage

// File: rtl/updi_baud_counter.sv
// Free-running bit-period counter: 0..CLKS_PER_BIT-1, held at zero while clear=1.
module updi_baud_counter #(
   parameter int CLKS_PER_BIT = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt_q <= '0;
      else if (cnt_q == LAST)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + CW'(1);
   end

   assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/updi_tx_frame.sv
// UPDI TX line stage: 8E2 UART framing with break pass-through from updi_double_break.
// Optional macro UPDI_TX_GUARD_EN appends GUARD_BITS idle-high bits after each frame.
module updi_tx_frame
   import updi_pkg::*;
#(
   parameter int CLKS_PER_BIT = 100,
   parameter int GUARD_BITS   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   input  logic       brk_busy,
   input  logic       brk_pulse,
   output logic       tx_out,
   output logic       tx_oe,
   output logic       busy
);

   localparam int IW = (GUARD_BITS > 8) ? $clog2(GUARD_BITS) : 3;

   updi_tx_state_t state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [7:0]     byte_q, byte_d;
   logic           par_q, par_d;
   logic           line_q, line_d;
   logic           tick;
   logic           baud_clear;
   logic           active;

   assign active     = (state_q != TX_IDLE);
   assign baud_clear = !active || brk_busy;
   assign data_ready = !active && !brk_busy && !rst;

   updi_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (baud_clear),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      byte_d  = byte_q;
      par_d   = par_q;
      if (brk_busy) begin
         state_d = TX_IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            TX_IDLE:
               if (data_valid && data_ready) begin
                  state_d = TX_START;
                  byte_d  = data_in;
                  par_d   = ^data_in;
                  idx_d   = '0;
               end
            TX_START:  if (tick) state_d = TX_DATA;
            TX_DATA:
               if (tick) begin
                  if (idx_q[2:0] == 3'd7) begin
                     state_d = TX_PARITY;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
            TX_PARITY: if (tick) state_d = TX_STOP1;
            TX_STOP1:  if (tick) state_d = TX_STOP2;
`ifdef UPDI_TX_GUARD_EN
            TX_STOP2:
               if (tick) begin
                  state_d = (GUARD_BITS > 0) ? TX_GUARD : TX_IDLE;
                  idx_d   = '0;
               end
            TX_GUARD:
               if (tick) begin
                  if (idx_q == IW'(GUARD_BITS - 1)) begin
                     state_d = TX_IDLE;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
`else
            TX_STOP2:  if (tick) state_d = TX_IDLE;
`endif
            default:   state_d = TX_IDLE;
         endcase
      end

      // Line level is precomputed from the next state so tx_out comes straight from a flop.
      case (state_d)
         TX_START:  line_d = 1'b0;
         TX_DATA:   line_d = byte_d[idx_d[2:0]];
         TX_PARITY: line_d = par_d;
         default:   line_d = UPDI_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TX_IDLE;
         idx_q   <= '0;
         byte_q  <= '0;
         par_q   <= 1'b0;
         line_q  <= UPDI_IDLE_LEVEL;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         byte_q  <= byte_d;
         par_q   <= par_d;
         line_q  <= line_d;
      end
   end

   assign busy   = active && !rst;
   assign tx_oe  = !rst && (active || brk_busy);
   assign tx_out = rst      ? UPDI_IDLE_LEVEL :
                   brk_busy ? brk_pulse       : line_q;

endmodule
